// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares one register-file write port between two writeback sources
// Ports:
//   clk, rst (async, active-low)
//   req{0,1}_valid/addr/data in, req{0,1}_ready out : per-source 2-entry queue handshake
//   RegWrite/wraddr/wrdata out                      : registered register-file write port
//   qaddr in, qhit out                              : pending-write query for hazard logic
// Build option: RF_ARB_FIXED_PRIO_EN makes source 0 always win; the default is round-robin.
module rf_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          RegWrite,
  output logic [AW-1:0] wraddr,
  output logic [DW-1:0] wrdata,
  input  logic [AW-1:0] qaddr,
  output logic          qhit
);
  // Queue storage is indexed [source][slot]; slot 0 is always the head.
  logic [AW-1:0] r_addr [2][2];
  logic [DW-1:0] r_data [2][2];
  logic [1:0]    r_cnt  [2];
  logic [AW-1:0] w_in_addr [2];
  logic [DW-1:0] w_in_data [2];
  logic [1:0]    w_ne, w_push, w_pop, w_slot;
  logic          w_g1;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;
  assign w_in_addr[0] = req0_addr;
  assign w_in_addr[1] = req1_addr;
  assign w_in_data[0] = req0_data;
  assign w_in_data[1] = req1_data;
  // Ready depends only on the current count, so a same-cycle pop never opens a full queue.
  assign req0_ready = r_cnt[0] != 2'd2;
  assign req1_ready = r_cnt[1] != 2'd2;
  assign w_ne   = {r_cnt[1] != 2'd0, r_cnt[0] != 2'd0};
  assign w_push = {req1_valid && req1_ready, req0_valid && req0_ready};
`ifdef RF_ARB_FIXED_PRIO_EN
  assign w_g1 = w_ne[1] && !w_ne[0];
`else
  logic r_rr;
  assign w_g1 = w_ne[1] && (!w_ne[0] || r_rr);
  // r_rr=1 favors source 1; it flips only on a grant, so idle cycles keep the preference.
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_rr <= 1'b0;
    else if (|w_pop) r_rr <= w_pop[0];
`endif
  assign w_pop = {w_g1, w_ne[0] && !w_g1};
  // A push lands at index cnt-pop, which is 0 or 1 since a full queue never accepts.
  assign w_slot[0] = r_cnt[0][0] && !w_pop[0];
  assign w_slot[1] = r_cnt[1][0] && !w_pop[1];
  assign w_head_addr = w_g1 ? r_addr[1][0] : r_addr[0][0];
  assign w_head_data = w_g1 ? r_data[1][0] : r_data[0][0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        r_cnt[s] <= 2'd0;
        for (int i = 0; i < 2; i++) begin
          r_addr[s][i] <= '0;
          r_data[s][i] <= '0;
        end
      end
      RegWrite <= 1'b0;
      wraddr   <= '0;
      wrdata   <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_pop[s]) begin
          r_addr[s][0] <= r_addr[s][1];
          r_data[s][0] <= r_data[s][1];
        end
        if (w_push[s]) begin
          r_addr[s][w_slot[s]] <= w_in_addr[s];
          r_data[s][w_slot[s]] <= w_in_data[s];
        end
        r_cnt[s] <= r_cnt[s] + {1'b0, w_push[s]} - {1'b0, w_pop[s]};
      end
      // Register 0 consumes its grant but never enables the write.
      RegWrite <= |w_pop && w_head_addr != '0;
      if (|w_pop) begin
        wraddr <= w_head_addr;
        wrdata <= w_head_data;
      end
    end
  // Slot 1 is valid only when the queue holds two entries.
  assign qhit = qaddr != '0 && (
                (RegWrite && wraddr == qaddr) ||
                (w_ne[0]     && r_addr[0][0] == qaddr) ||
                (r_cnt[0][1] && r_addr[0][1] == qaddr) ||
                (w_ne[1]     && r_addr[1][0] == qaddr) ||
                (r_cnt[1][1] && r_addr[1][1] == qaddr));
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port (`RegWrite`/`wraddr`/`wrdata`) between two writeback sources: the main pipeline writeback and a secondary long-latency unit (multiply/divide or load return). Each source gets a 2-entry queue with a valid/ready handshake. A round-robin arbiter drains one entry per cycle into a registered write port. A query port reports whether a register has a write still pending, so hazard logic can stall readers.

## Interface
- `DW`, 32, data width
- `AW`, 5, register address width
- `clk  in  1  clock; all state updates on rising edge`
- `rst  in  1  asynchronous, active-low reset`
- `req0_valid  in  1  source 0 has a write`
- `req0_addr  in  AW  source 0 destination register`
- `req0_data  in  DW  source 0 write data`
- `req0_ready  out  1  source 0 queue can accept`
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as source 0, for source 1
- `RegWrite  out  1  registered write enable to register file`
- `wraddr  out  AW  registered write address`
- `wrdata  out  DW  registered write data`
- `qaddr  in  AW  query register address`
- `qhit  out  1  combinational: write to nonzero `qaddr` is queued or on the port this cycle`

## Operation
- Queues:
  - One 2-entry FIFO per source.
  - Accept happens on the edge where `reqN_valid && reqN_ready`.
  - `reqN_ready = !fullN`.
  - No push-while-full bypass: a pop in the same cycle does not make a full queue ready.
- Arbitration:
  - Each cycle, at most one queue head is popped.
  - If only one queue is non-empty, that queue is granted.
  - If both are non-empty, the queue favored by the round-robin pointer `rr` is granted.
  - After a grant, `rr` favors the other source.
  - `rr` does not change on idle cycles.
- Write port:
  - A popped entry drives `RegWrite=1`, `wraddr`, `wrdata` on the next cycle.
  - With no pop, `RegWrite=0` and `wraddr`/`wrdata` hold their previous values.
- Register 0:
  - An entry with addr 0 is accepted and popped normally, consuming its grant.
  - It produces `RegWrite=0` on the following cycle.
- Ordering:
  - FIFO order is kept within a source.
  - No order is guaranteed across sources for the same address; the producers must not issue that case.
- `qhit`:
  - Asserted when `qaddr != 0` and it matches any valid entry in either queue, or the address currently on the write port with `RegWrite=1`.
- Reset (`rst=0`, asynchronous):
  - Both queues are emptied.
  - `rr` favors source 0.
  - `RegWrite=0`, `wraddr=0`, `wrdata=0`.
  - `req0_ready` and `req1_ready` are 1 after reset release.
  - `qhit=0` for any `qaddr`.
  - Reset asserted mid-operation discards all queued writes, and no `RegWrite` follows.

## Timing
- Minimum latency: accept at edge N, then `RegWrite=1` in the cycle after edge N+1. That is one cycle from accept to write enable.
- Throughput: one register-file write per cycle combined across both sources. A single source alone sustains one per cycle.
- Under contention, each source gets at least every other write cycle.
- A queue goes full on the second accept without an intervening pop. It stays not-ready until a pop edge.
- Simultaneous accept and pop on the same queue keeps occupancy unchanged. The popped entry is the old head.

## Configuration
- `RF_ARB_FIXED_PRIO_EN`:
  - Defined: source 0 always wins when both queues are non-empty, and `rr` is not implemented.
  - Undefined (default): round-robin as above.

## Test plan
- Reset, then source 0 pushes (addr 5, 0xDEADBEEF) → next cycle `RegWrite=1`, `wraddr=5`, `wrdata=0xDEADBEEF`. While the entry is queued and on the port, `qhit=1` for `qaddr=5`.
- Both sources push continuously (source 0 addrs 1,2,3; source 1 addrs 9,10,11) → write order 1,9,2,10,3,11. With `RF_ARB_FIXED_PRIO_EN` the order is 1,2,3,9,10,11.
- Source 1 pushes 3 entries back-to-back while source 0 also floods → `req1_ready` drops after 2 accepts and returns after a source-1 grant. No entry is lost or duplicated.
- Push addr 0 with data 0x1234 → `RegWrite` stays 0 and `qhit=0` for `qaddr=0`. A following push to addr 7 writes one cycle later.
- Fill both queues, then assert `rst=0` for one cycle mid-stream → `RegWrite=0`, both readies 1, and no stale writes after release.
- Idle for 10 cycles after a source-1 grant, then both push at once → source 0 is granted first, showing `rr` was held.
